// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU with a
// fixed busy latency and serves MFHI/MFLO reads combinationally.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] e_rd1,
    input  logic [31:0] e_rd2,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] mdu_rd
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      op_q;
    logic [31:0]     rs_q;
    logic [31:0]     rt_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic [63:0]     res_d;

    // Returns {HI, LO} for an MDU arithmetic op; signed divide works on magnitudes
    // so the INT_MIN / -1 case falls out as quotient 0x80000000, remainder 0.
    function automatic logic [63:0] mdu_calc(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] result;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        result = 64'd0;
        mag_a  = a[31] ? (32'd0 - a) : a;
        mag_b  = b[31] ? (32'd0 - b) : b;
        quo    = 32'd0;
        rem    = 32'd0;
        case (op)
            OP_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            OP_MULTU: result = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) begin
                    result = {a, 32'hFFFF_FFFF};
                end else begin
                    quo    = mag_a / mag_b;
                    rem    = mag_a % mag_b;
                    result = {(a[31] ? (32'd0 - rem) : rem),
                              ((a[31] ^ b[31]) ? (32'd0 - quo) : quo)};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    result = {a, 32'hFFFF_FFFF};
                end else begin
                    result = {a % b, a / b};
                end
            end
            default: result = 64'd0;
        endcase
        return result;
    endfunction

    // Result of the in-flight op, taken only from latched operands
    always_comb begin
        res_d = mdu_calc(op_q, rs_q, rt_q);
    end

    // Control FSM together with operand latches and HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (mdu_op)
                            OP_MULT, OP_MULTU: begin
                                op_q    <= mdu_op;
                                rs_q    <= e_rd1;
                                rt_q    <= e_rd2;
                                cnt_q   <= CW'(MULT_CYCLES);
                                state_q <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q    <= mdu_op;
                                rs_q    <= e_rd1;
                                rt_q    <= e_rd2;
                                cnt_q   <= CW'(DIV_CYCLES);
                                state_q <= S_RUN;
                            end
                            OP_MTHI: hi_q <= e_rd1;
                            OP_MTLO: lo_q <= e_rd1;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        hi_q    <= res_d[63:32];
                        lo_q    <= res_d[31:0];
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read port follows mdu_op alone; the hazard unit handles ordering
    always_comb begin
        case (mdu_op)
            OP_MFHI: mdu_rd = hi_q;
            OP_MFLO: mdu_rd = lo_q;
            default: mdu_rd = 32'd0;
        endcase
    end

    assign busy   = (state_q == S_RUN);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
